dmem_responder: RTL

- Memory-side responder for the core's data-memory interface.
- Accepts load/store requests from the core through a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a single response (read data or write acknowledge) with an error flag.
- Replaces the zero-latency data memory with a realistic multi-cycle slave, so the core's stall logic can be exercised.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_byte_ram.sv | 25 ++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed RAM with per-byte write enable and a registered read port.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-masked write and read sample; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= be_merge(mem[idx], wdata, be);
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: one outstanding request, programmable wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              commit;

    logic [31:0]       addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    logic [31:0]       cur_addr;
    logic              cur_we;
    logic [BE_W-1:0]   cur_be;
    logic [DATA_W-1:0] cur_wdata;
    logic [31:0]       offset;
    logic              cur_err;
    logic [IDX_W-1:0]  idx;

    logic              err_q;
    logic              rd_ok_q;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // Live request fields in IDLE, latched fields afterwards: with zero latency
    // the access commits on the acceptance edge, before the latches are loaded.
    always_comb begin
        cur_addr  = (state == IDLE) ? req_addr  : addr_q;
        cur_we    = (state == IDLE) ? req_we    : we_q;
        cur_be    = (state == IDLE) ? req_be    : be_q;
        cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
        offset    = cur_addr - BASE_ADDR;
        idx       = offset[IDX_W+1:2];
        cur_err   = (offset[1:0] != 2'b00)
                  | (offset[31:IDX_W+2] != '0)
                  | (cur_we & (cur_be == '0));
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, handshake outputs and commit strobe.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        commit    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch on acceptance; response status captured at commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                err_q   <= cur_err;
                rd_ok_q <= ~cur_we & ~cur_err;
            end
        end
    end

    assign ram_we = commit & cur_we & ~cur_err;
    assign ram_re = commit & ~cur_we & ~cur_err;

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .be    (cur_be),
        .idx   (idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid & rd_ok_q) ? ram_rdata : '0;

endmodule
